// File: rtl/qsfp_poll_scheduler.sv
// Purpose: shares the i2c_chunk result read port between a host and a periodic poller that builds a coherent 4-byte QSFP snapshot.
// Latency: host ack LB_LATENCY+2 cycles after grant; a poll occupies FREEZE_SETTLE+4*(LB_LATENCY+1)+1 cycles with freeze held.
// Backpressure: host_req is a held level; it waits while a poll is pending or running and is granted only from IDLE.
module qsfp_poll_scheduler #(
  parameter int         POLL_INTERVAL = 100000000,
  parameter int         FREEZE_SETTLE = 2,
  parameter int         LB_LATENCY    = 1,
  parameter int         STALE_POLLS   = 4,
  parameter logic [9:0] PORT0_OFFSET  = 10'h000,
  parameter logic [9:0] PORT1_OFFSET  = 10'h001,
  parameter logic [9:0] STAT1_OFFSET  = 10'h002,
  parameter logic [9:0] STAT2_OFFSET  = 10'h003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic [11:0] host_addr,
  output logic        host_ack,
  output logic [7:0]  host_data,
  output logic [11:0] lb_addr,
  input  logic [7:0]  lb_dout,
  output logic        freeze,
  input  logic        updated,
  input  logic        run_stat,
  output logic [7:0]  snap_port0,
  output logic [7:0]  snap_port1,
  output logic [7:0]  snap_stat1,
  output logic [7:0]  snap_stat2,
  output logic        snap_strobe,
  output logic        stale
);

  localparam int IW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int CW = ($clog2(FREEZE_SETTLE) > 2) ? $clog2(FREEZE_SETTLE) : 2;
  localparam int SW = $clog2(STALE_POLLS + 1);
  localparam logic [IW-1:0] INT_LAST  = IW'(POLL_INTERVAL - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(LB_LATENCY);
  localparam logic [CW-1:0] FRZ_LAST  = CW'(FREEZE_SETTLE - 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_POLLS);
  localparam logic [11:0]   RES_BASE  = 12'h800;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST,
    S_FRZ,
    S_PREAD,
    S_REL
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   int_cnt_q, int_cnt_d;
  logic            poll_pend_q, poll_pend_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [1:0]      idx_q, idx_d;
  logic [11:0]     haddr_q, haddr_d;
  logic [11:0]     lb_addr_q, lb_addr_d;
  logic            freeze_q, freeze_d;
  logic            host_ack_q, host_ack_d;
  logic [7:0]      host_data_q, host_data_d;
  logic [7:0]      stage0_q, stage0_d;
  logic [7:0]      stage1_q, stage1_d;
  logic [7:0]      stage2_q, stage2_d;
  logic [7:0]      snap_port0_q, snap_port0_d;
  logic [7:0]      snap_port1_q, snap_port1_d;
  logic [7:0]      snap_stat1_q, snap_stat1_d;
  logic [7:0]      snap_stat2_q, snap_stat2_d;
  logic            snap_strobe_q, snap_strobe_d;
  logic [SW-1:0]   stale_cnt_q, stale_cnt_d;
  logic            stale_q, stale_d;
  logic            upd_prev_q, upd_prev_d;

  logic            wrap;
  logic            poll_req;
  logic            upd_edge;
  logic            poll_done;
  logic [9:0]      cur_off;

  // Next-state logic: interval timer, arbitration FSM, snapshot capture and stale tracking.
  always_comb begin
    state_d       = state_q;
    int_cnt_d     = int_cnt_q;
    poll_pend_d   = poll_pend_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    haddr_d       = haddr_q;
    lb_addr_d     = RES_BASE;
    freeze_d      = 1'b0;
    host_ack_d    = 1'b0;
    host_data_d   = host_data_q;
    stage0_d      = stage0_q;
    stage1_d      = stage1_q;
    stage2_d      = stage2_q;
    snap_port0_d  = snap_port0_q;
    snap_port1_d  = snap_port1_q;
    snap_stat1_d  = snap_stat1_q;
    snap_stat2_d  = snap_stat2_q;
    snap_strobe_d = 1'b0;
    stale_cnt_d   = stale_cnt_q;
    stale_d       = stale_q;
    upd_prev_d    = updated;
    poll_done     = 1'b0;
    cur_off       = PORT0_OFFSET;

    // A wrap counts as pending in its own cycle so a simultaneous host request loses.
    wrap        = (int_cnt_q == INT_LAST);
    int_cnt_d   = wrap ? '0 : int_cnt_q + 1'b1;
    poll_req    = poll_pend_q | wrap;
    poll_pend_d = poll_req;
    upd_edge    = updated & ~upd_prev_q;

    case (state_q)
      S_IDLE: begin
        if (poll_req) begin
          poll_pend_d = 1'b0;
          if (run_stat) begin
            state_d = S_FRZ;
            phase_d = '0;
          end else begin
            // i2c_chunk not running: the poll is skipped but still ages the data.
            poll_done = 1'b1;
          end
        end else if (host_req && !host_ack_q) begin
          // The ack cycle is excluded so a request still high during ack is not regranted.
          haddr_d = host_addr;
          phase_d = '0;
          state_d = S_HOST;
        end
      end
      S_HOST: begin
        if (phase_q == WIN_LAST) begin
          host_data_d = lb_dout;
          host_ack_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_FRZ: begin
        if (phase_q == FRZ_LAST) begin
          phase_d = '0;
          idx_d   = 2'd0;
          state_d = S_PREAD;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_PREAD: begin
        if (phase_q == WIN_LAST) begin
          phase_d = '0;
          idx_d   = idx_q + 2'd1;
          case (idx_q)
            2'd0: stage0_d = lb_dout;
            2'd1: stage1_d = lb_dout;
            2'd2: stage2_d = lb_dout;
            default: begin
              // Last byte goes straight to the snapshot so all four update together.
              snap_port0_d  = stage0_q;
              snap_port1_d  = stage1_q;
              snap_stat1_d  = stage2_q;
              snap_stat2_d  = lb_dout;
              snap_strobe_d = 1'b1;
              state_d       = S_REL;
            end
          endcase
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_REL: begin
        poll_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An updated edge beats a same-cycle poll completion.
    if (upd_edge) begin
      stale_cnt_d = '0;
    end else if (poll_done && (stale_cnt_q != STALE_MAX)) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
    stale_d = (stale_cnt_d == STALE_MAX);

    case (idx_d)
      2'd0:    cur_off = PORT0_OFFSET;
      2'd1:    cur_off = PORT1_OFFSET;
      2'd2:    cur_off = STAT1_OFFSET;
      default: cur_off = STAT2_OFFSET;
    endcase

    // Bus outputs are registered from the next state so they align with the state they belong to.
    freeze_d = (state_d == S_FRZ) || (state_d == S_PREAD) || (state_d == S_REL);
    if (state_d == S_HOST) begin
      lb_addr_d = haddr_d;
    end else if (state_d == S_PREAD) begin
      lb_addr_d = RES_BASE | {2'b00, cur_off};
    end
  end

  // State register with synchronous reset; reset discards any in-flight poll or host read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      int_cnt_q     <= '0;
      poll_pend_q   <= 1'b0;
      phase_q       <= '0;
      idx_q         <= 2'd0;
      haddr_q       <= 12'h000;
      lb_addr_q     <= RES_BASE;
      freeze_q      <= 1'b0;
      host_ack_q    <= 1'b0;
      host_data_q   <= 8'h00;
      stage0_q      <= 8'h00;
      stage1_q      <= 8'h00;
      stage2_q      <= 8'h00;
      snap_port0_q  <= 8'h00;
      snap_port1_q  <= 8'h00;
      snap_stat1_q  <= 8'h00;
      snap_stat2_q  <= 8'h00;
      snap_strobe_q <= 1'b0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b0;
      upd_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_cnt_q     <= int_cnt_d;
      poll_pend_q   <= poll_pend_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      haddr_q       <= haddr_d;
      lb_addr_q     <= lb_addr_d;
      freeze_q      <= freeze_d;
      host_ack_q    <= host_ack_d;
      host_data_q   <= host_data_d;
      stage0_q      <= stage0_d;
      stage1_q      <= stage1_d;
      stage2_q      <= stage2_d;
      snap_port0_q  <= snap_port0_d;
      snap_port1_q  <= snap_port1_d;
      snap_stat1_q  <= snap_stat1_d;
      snap_stat2_q  <= snap_stat2_d;
      snap_strobe_q <= snap_strobe_d;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
      upd_prev_q    <= upd_prev_d;
    end
  end

  assign host_ack    = host_ack_q;
  assign host_data   = host_data_q;
  assign lb_addr     = lb_addr_q;
  assign freeze      = freeze_q;
  assign snap_port0  = snap_port0_q;
  assign snap_port1  = snap_port1_q;
  assign snap_stat1  = snap_stat1_q;
  assign snap_stat2  = snap_stat2_q;
  assign snap_strobe = snap_strobe_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_qsfp_poll_scheduler.sv
// Bench for qsfp_poll_scheduler: an i2c_chunk memory model answers lb_addr after one cycle,
// and expectations come from that memory plus the timing rules of the block.
module tb_qsfp_poll_scheduler;

  localparam int PI = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req = 1'b0;
  logic [11:0] host_addr = 12'h000;
  logic        host_ack;
  logic [7:0]  host_data;
  logic [11:0] lb_addr;
  logic [7:0]  lb_dout = 8'h00;
  logic        freeze;
  logic        updated = 1'b0;
  logic        run_stat = 1'b1;
  logic [7:0]  snap_port0, snap_port1, snap_stat1, snap_stat2;
  logic        snap_strobe;
  logic        stale;

  logic [7:0]  mem [0:4095];
  logic [7:0]  exp_snap [4];
  int          vectors = 0;
  int          miscompares = 0;

  qsfp_poll_scheduler #(
    .POLL_INTERVAL(PI),
    .FREEZE_SETTLE(2),
    .LB_LATENCY(1),
    .STALE_POLLS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack), .host_data(host_data),
    .lb_addr(lb_addr), .lb_dout(lb_dout), .freeze(freeze),
    .updated(updated), .run_stat(run_stat),
    .snap_port0(snap_port0), .snap_port1(snap_port1), .snap_stat1(snap_stat1), .snap_stat2(snap_stat2),
    .snap_strobe(snap_strobe), .stale(stale)
  );

  always #5 clk = ~clk;

  // i2c_chunk result memory with one cycle of read latency.
  always @(posedge clk) lb_dout <= mem[lb_addr];

  task automatic scramble();
    for (int i = 0; i < 4; i++) mem[12'h800 + i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[$urandom_range(0, 4095)] = 8'($urandom);
  endtask

  task automatic wait_freeze_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (freeze === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL freeze_rise_timeout: freeze=%b after 200 cycles, required 1", freeze);
    end
  endtask

  task automatic wait_freeze_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (freeze === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL freeze_fall_timeout: freeze=%b after 40 cycles, required 0", freeze);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({lb_addr, freeze, host_ack, host_data, snap_port0, snap_port1, snap_stat1, snap_stat2,
         snap_strobe, stale} !== {12'h800, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: lb_addr=%h freeze=%b ack=%b data=%h snap=%h%h%h%h strobe=%b stale=%b, required 800/0/0/00/00000000/0/0",
               lb_addr, freeze, host_ack, host_data, snap_port0, snap_port1, snap_stat1, snap_stat2,
               snap_strobe, stale);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_snap[i] = 8'h00;
  endtask

  task automatic test_reset_mid_poll();
    bit ok;
    logic [7:0] nxt [4];
    wait_freeze_rise(ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (lb_addr !== 12'h801) begin
      miscompares++;
      $display("FAIL midrst_addr: lb_addr=%h, required 801", lb_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({freeze, snap_strobe, host_ack, snap_port0, snap_port1, snap_stat1, snap_stat2} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL midrst_state: freeze=%b strobe=%b ack=%b snap=%h%h%h%h, required 0/0/0/00000000",
               freeze, snap_strobe, host_ack, snap_port0, snap_port1, snap_stat1, snap_stat2);
    end
    @(negedge clk);
    rst = 1'b0;
    scramble();
    for (int i = 0; i < 4; i++) nxt[i] = mem[12'h800 + i];
    wait_freeze_rise(ok);
    wait_freeze_fall(ok);
    vectors++;
    if ({snap_port0, snap_port1, snap_stat1, snap_stat2} !== {nxt[0], nxt[1], nxt[2], nxt[3]}) begin
      miscompares++;
      $display("FAIL midrst_recover: snap=%h%h%h%h, required %h%h%h%h",
               snap_port0, snap_port1, snap_stat1, snap_stat2, nxt[0], nxt[1], nxt[2], nxt[3]);
    end
    for (int i = 0; i < 4; i++) exp_snap[i] = nxt[i];
  endtask

  task automatic test_poll(input int n);
    bit ok;
    logic [7:0] nxt [4];
    logic [7:0] e [4];
    logic [11:0] ea;
    for (int p = 0; p < n; p++) begin
      wait_freeze_fall(ok);
      scramble();
      for (int i = 0; i < 4; i++) nxt[i] = mem[12'h800 + i];
      wait_freeze_rise(ok);
      if (ok) begin
        // k counts freeze cycles: 1..11 high, strobe on the 11th, then one idle cycle.
        for (int k = 1; k <= 12; k++) begin
          for (int i = 0; i < 4; i++) e[i] = (k >= 11) ? nxt[i] : exp_snap[i];
          vectors++;
          if ({freeze, snap_strobe, snap_port0, snap_port1, snap_stat1, snap_stat2} !==
              {(k <= 11), (k == 11), e[0], e[1], e[2], e[3]}) begin
            miscompares++;
            $display("FAIL poll k=%0d: freeze=%b strobe=%b snap=%h%h%h%h, required %b/%b/%h%h%h%h",
                     k, freeze, snap_strobe, snap_port0, snap_port1, snap_stat1, snap_stat2,
                     (k <= 11), (k == 11), e[0], e[1], e[2], e[3]);
          end
          if (k >= 3 && k <= 10) begin
            ea = 12'h800 + 12'((k - 3) / 2);
            vectors++;
            if (lb_addr !== ea) begin
              miscompares++;
              $display("FAIL poll_addr k=%0d: lb_addr=%h, required %h", k, lb_addr, ea);
            end
          end
          if (k < 12) @(negedge clk);
        end
      end
      for (int i = 0; i < 4; i++) exp_snap[i] = nxt[i];
    end
  endtask

  task automatic test_host_read(input int n, input int max_gap);
    bit ok;
    logic [11:0] a;
    logic [7:0] d;
    wait_freeze_fall(ok);
    wait_freeze_rise(ok);
    wait_freeze_fall(ok);
    for (int r = 0; r < n; r++) begin
      if (r == 0 && max_gap > 0) begin
        a = 12'h805;
        mem[a] = 8'hA5;
      end else begin
        a = 12'($urandom);
      end
      d = mem[a];
      host_addr = a;
      host_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        vectors++;
        if (k <= 2) begin
          if ({lb_addr, host_ack, freeze} !== {a, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL host_window k=%0d: lb_addr=%h ack=%b freeze=%b, required %h/0/0", k, lb_addr, host_ack, freeze, a);
          end
        end else begin
          if ({host_ack, host_data, freeze} !== {(k == 3), d, 1'b0}) begin
            miscompares++;
            $display("FAIL host_ack k=%0d addr=%h: ack=%b data=%h freeze=%b, required %b/%h/0",
                     k, a, host_ack, host_data, freeze, (k == 3), d);
          end
          if (k == 3) host_req = 1'b0;
        end
      end
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    test_host_read(8, 0);
  endtask

  task automatic test_contention();
    bit ok;
    logic [11:0] a;
    logic [7:0] d;
    wait_freeze_fall(ok);
    wait_freeze_rise(ok);
    wait_freeze_fall(ok);
    // Now in the cycle 12 after the last wrap; step to the next wrap cycle.
    repeat (PI - 12) @(negedge clk);
    a = 12'($urandom);
    d = mem[a];
    host_addr = a;
    host_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      vectors++;
      if ({freeze, host_ack} !== {(k <= 11), (k == 15)}) begin
        miscompares++;
        $display("FAIL contention k=%0d: freeze=%b ack=%b, required %b/%b", k, freeze, host_ack, (k <= 11), (k == 15));
      end
      if (k == 15) begin
        vectors++;
        if (host_data !== d) begin
          miscompares++;
          $display("FAIL contention_data: data=%h, required %h", host_data, d);
        end
        host_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) exp_snap[i] = mem[12'h800 + i];
  endtask

  task automatic test_stale();
    bit ok;
    wait_freeze_fall(ok);
    updated = 1'b1;
    @(negedge clk);
    updated = 1'b0;
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_clear0: stale=%b, required 0", stale);
    end
    for (int i = 1; i <= 4; i++) begin
      wait_freeze_rise(ok);
      wait_freeze_fall(ok);
      vectors++;
      if (stale !== (i == 4)) begin
        miscompares++;
        $display("FAIL stale_count poll=%0d: stale=%b, required %b", i, stale, (i == 4));
      end
    end
    updated = 1'b1;
    @(negedge clk);
    updated = 1'b0;
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_clear1: stale=%b, required 0", stale);
    end
    for (int i = 1; i <= 3; i++) begin
      wait_freeze_rise(ok);
      wait_freeze_fall(ok);
      vectors++;
      if (stale !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_partial poll=%0d: stale=%b, required 0", i, stale);
      end
    end
    wait_freeze_rise(ok);
    repeat (10) @(negedge clk);
    vectors++;
    if (snap_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_rel_align: strobe=%b, required 1", snap_strobe);
    end
    updated = 1'b1;
    @(negedge clk);
    updated = 1'b0;
    vectors++;
    if ({stale, freeze} !== 2'b00) begin
      miscompares++;
      $display("FAIL stale_coincide: stale=%b freeze=%b, required 0/0", stale, freeze);
    end
    wait_freeze_rise(ok);
    wait_freeze_fall(ok);
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_after_coincide: stale=%b, required 0", stale);
    end
  endtask

  task automatic test_skip();
    bit ok;
    int bad;
    bad = 0;
    wait_freeze_fall(ok);
    run_stat = 1'b0;
    updated = 1'b1;
    @(negedge clk);
    updated = 1'b0;
    for (int t = 1; t < 262; t++) begin
      if (t % 20 == 0) scramble();
      @(negedge clk);
      if (freeze !== 1'b0 || snap_strobe !== 1'b0) bad++;
      if (t == 179 || t == 261) begin
        vectors++;
        if ({stale, bad != 0, snap_port0, snap_port1, snap_stat1, snap_stat2} !==
            {(t == 261), 1'b0, exp_snap[0], exp_snap[1], exp_snap[2], exp_snap[3]}) begin
          miscompares++;
          $display("FAIL skip t=%0d: stale=%b bad_cycles=%0d snap=%h%h%h%h, required %b/0/%h%h%h%h",
                   t, stale, bad, snap_port0, snap_port1, snap_stat1, snap_stat2,
                   (t == 261), exp_snap[0], exp_snap[1], exp_snap[2], exp_snap[3]);
        end
      end
    end
    run_stat = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) exp_snap[i] = 8'h00;
    test_reset();
    test_reset_mid_poll();
    test_poll(3);
    test_host_read(6, 2);
    test_back_to_back();
    test_contention();
    test_stale();
    test_skip();
    test_poll(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
